// File: rtl/skolem_urem_search.sv
// Sequential smallest-witness search for unsigned-remainder constraints, one restoring division per candidate.
// Optional macro SKOLEM_URSEARCH_IC_PRECHECK_EN: skip the search when the invertibility condition fails.
module skolem_urem_search #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    input  logic [WIDTH-1:0] s_in,
    input  logic [WIDTH-1:0] t_in,
    input  logic [1:0]       mode,
    output logic             done,
    output logic             found,
    output logic [WIDTH-1:0] x_out
);

    localparam int unsigned CNT_W = WIDTH + 1;
    localparam int unsigned BC_W  = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CAND_LAST = {1'b0, {WIDTH{1'b1}}};
    localparam logic [BC_W-1:0]  BIT_LAST  = BC_W'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, LOAD, DIV, CHECK, DONE} state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] t_q;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] cand;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] dvd_sh;
    logic [WIDTH-1:0] dvd_orig;
    logic [WIDTH-1:0] dvs;
    logic [BC_W-1:0]  bit_cnt;

    logic [CNT_W-1:0] cand_inc_c;
    logic [WIDTH:0]   rem_sh_c;
    logic [WIDTH:0]   dvs_ext_c;
    logic [WIDTH:0]   rem_fin_c;
    logic             pass_c;
    logic             last_c;

    logic             accept_c;
    logic             init_c;
    logic             step_c;
    logic             hit_c;
    logic             miss_c;
    logic [WIDTH-1:0] init_x_c;

    // Divider step, zero-divisor remainder override and predicate evaluation
    always_comb begin
        cand_inc_c = cand + CNT_W'(1);
        rem_sh_c   = {rem[WIDTH-1:0], dvd_sh[WIDTH-1]};
        dvs_ext_c  = {1'b0, dvs};
        rem_fin_c  = (dvs == '0) ? {1'b0, dvd_orig} : rem;
        pass_c     = mode_q[0] ? (rem_fin_c < {1'b0, t_q}) : (rem_fin_c > {1'b0, t_q});
        last_c     = (cand == CAND_LAST);
    end

`ifdef SKOLEM_URSEARCH_IC_PRECHECK_EN
    logic [WIDTH-1:0] neg_s_c;
    logic             ic_ok_c;

    // Invertibility condition: when false no candidate can ever pass
    always_comb begin
        neg_s_c = WIDTH'(0) - s_q;
        case (mode_q)
            2'b00:   ic_ok_c = (t_q < ~neg_s_c);
            2'b10:   ic_ok_c = (t_q < s_q);
            default: ic_ok_c = (t_q != '0);
        endcase
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
`ifdef SKOLEM_URSEARCH_IC_PRECHECK_EN
                state_nxt = ic_ok_c ? DIV : DONE;
`else
                state_nxt = DIV;
`endif
            end
            DIV: begin
                if (bit_cnt == BIT_LAST) state_nxt = CHECK;
            end
            CHECK: begin
                state_nxt = (pass_c || last_c) ? DONE : DIV;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output and datapath control decode
    always_comb begin
        accept_c = 1'b0;
        init_c   = 1'b0;
        step_c   = 1'b0;
        hit_c    = 1'b0;
        miss_c   = 1'b0;
        init_x_c = cand[WIDTH-1:0];
        case (state)
            IDLE:  accept_c = start;
            LOAD:  init_c   = 1'b1;
            DIV:   step_c   = 1'b1;
            CHECK: begin
                hit_c    = pass_c;
                miss_c   = !pass_c && last_c;
                init_c   = !pass_c && !last_c;
                init_x_c = cand_inc_c[WIDTH-1:0];
            end
            default: ;
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            ready    <= 1'b1;
            done     <= 1'b0;
            found    <= 1'b0;
            x_out    <= '0;
            s_q      <= '0;
            t_q      <= '0;
            mode_q   <= '0;
            cand     <= '0;
            rem      <= '0;
            dvd_sh   <= '0;
            dvd_orig <= '0;
            dvs      <= '0;
            bit_cnt  <= '0;
        end else begin
            ready <= (state_nxt == IDLE);
            done  <= (state_nxt == DONE);
            if (accept_c) begin
                s_q    <= s_in;
                t_q    <= t_in;
                mode_q <= mode;
                found  <= 1'b0;
                x_out  <= '0;
                cand   <= '0;
            end
            // Operand order depends on which side of the urem the witness sits
            if (init_c) begin
                dvd_sh   <= mode_q[1] ? s_q : init_x_c;
                dvd_orig <= mode_q[1] ? s_q : init_x_c;
                dvs      <= mode_q[1] ? init_x_c : s_q;
                rem      <= '0;
                bit_cnt  <= '0;
                if (state == CHECK) cand <= cand_inc_c;
            end
            if (step_c) begin
                rem     <= (rem_sh_c >= dvs_ext_c) ? (rem_sh_c - dvs_ext_c) : rem_sh_c;
                dvd_sh  <= {dvd_sh[WIDTH-2:0], 1'b0};
                bit_cnt <= bit_cnt + BC_W'(1);
            end
            if (hit_c) begin
                found <= 1'b1;
                x_out <= cand[WIDTH-1:0];
            end
            if (miss_c) begin
                found <= 1'b0;
                x_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_skolem_urem_search.sv
// Bench for skolem_urem_search: directed cases, abort/ignore handshakes and a randomized sweep at WIDTH 4 and 6.
module tb_skolem_urem_search;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start4 = 1'b0;
    logic [3:0] s4 = '0;
    logic [3:0] t4 = '0;
    logic [1:0] mode4 = '0;
    logic       ready4, done4, found4;
    logic [3:0] x4;

    logic       start6 = 1'b0;
    logic [5:0] s6 = '0;
    logic [5:0] t6 = '0;
    logic [1:0] mode6 = '0;
    logic       ready6, done6, found6;
    logic [5:0] x6;

    int n_checks = 0;
    int n_fail   = 0;

    skolem_urem_search #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .ready(ready4),
        .s_in(s4), .t_in(t4), .mode(mode4),
        .done(done4), .found(found4), .x_out(x4)
    );

    skolem_urem_search #(.WIDTH(6)) u_dut6 (
        .clk(clk), .rst(rst), .start(start6), .ready(ready6),
        .s_in(s6), .t_in(t6), .mode(mode6),
        .done(done6), .found(found6), .x_out(x6)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Smallest witness by brute force over the whole candidate range
    function automatic void model(input int w, input logic [1:0] m, input int s, input int t,
                                  output logic f, output int x, output int lat);
        int n;
        int r;
        n = 1 << w;
        f = 1'b0;
        x = 0;
        for (int c = 0; c < n; c++) begin
            if (m[1]) r = (c == 0) ? s : s % c;
            else      r = (s == 0) ? c : c % s;
            if (m[0] ? (r < t) : (r > t)) begin
                f = 1'b1;
                x = c;
                break;
            end
        end
        lat = f ? 2 + (x + 1) * (w + 1) : 2 + n * (w + 1);
`ifdef SKOLEM_URSEARCH_IC_PRECHECK_EN
        begin
            bit ic;
            case (m)
                2'b00:   ic = t < ((s + n - 1) % n);
                2'b10:   ic = t < s;
                default: ic = t != 0;
            endcase
            if (!ic) lat = 2;
        end
`endif
    endfunction

    task automatic set_in(input int w, input logic st, input logic [1:0] m, input int s, input int t);
        if (w == 4) begin
            start4 = st; mode4 = m; s4 = 4'(s); t4 = 4'(t);
        end else begin
            start6 = st; mode6 = m; s6 = 6'(s); t6 = 6'(t);
        end
    endtask

    function automatic logic get_done(input int w);
        return (w == 4) ? done4 : done6;
    endfunction
    function automatic logic get_ready(input int w);
        return (w == 4) ? ready4 : ready6;
    endfunction
    function automatic logic get_found(input int w);
        return (w == 4) ? found4 : found6;
    endfunction
    function automatic int get_x(input int w);
        return (w == 4) ? int'(x4) : int'(x6);
    endfunction

    // One request; cycle 1 is the cycle right after the accepting edge
    task automatic run_op(input string tag, input int w, input logic [1:0] m, input int s, input int t,
                          input logic ef, input int ex, input int elat, input bit poke);
        int cyc;
        int limit;
        limit = 2 + (1 << w) * (w + 1) + 10;
        @(negedge clk);
        chk({tag, "_ready"}, get_ready(w), 1);
        set_in(w, 1'b1, m, s, t);
        @(negedge clk);
        cyc = 1;
        set_in(w, 1'b0, ~m, s + 5, t + 3);
        while (!get_done(w) && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 5) set_in(w, 1'b1, 2'b10, 7, 2);
            else if (poke && cyc == 6) set_in(w, 1'b0, 2'b01, 0, 0);
        end
        set_in(w, 1'b0, 2'b00, 0, 0);
        chk({tag, "_done"}, get_done(w), 1);
        chk({tag, "_lat"}, cyc, elat);
        chk({tag, "_found"}, get_found(w), ef);
        chk({tag, "_x"}, get_x(w), ex);
        @(negedge clk);
        chk({tag, "_pulse"}, get_done(w), 0);
        chk({tag, "_hold"}, get_x(w), ex);
    endtask

    task automatic run_rand(input string tag, input int w);
        logic [1:0] m;
        int s, t, ex, elat;
        logic ef;
        m = 2'($urandom_range(0, 3));
        s = int'($urandom_range(0, (1 << w) - 1));
        t = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, (1 << w) - 1));
        model(w, m, s, t, ef, ex, elat);
        run_op(tag, w, m, s, t, ef, ex, elat, 1'b0);
    endtask

    initial begin
        int done_seen;
        int lat_nosol;
        int lat_m01;

`ifdef SKOLEM_URSEARCH_IC_PRECHECK_EN
        lat_nosol = 2;
        lat_m01   = 2;
`else
        lat_nosol = 82;
        lat_m01   = 82;
`endif

        repeat (3) @(negedge clk);
        chk("rst_ready4", ready4, 1);
        chk("rst_done4", done4, 0);
        chk("rst_found4", found4, 0);
        chk("rst_x4", x4, 0);
        chk("rst_ready6", ready6, 1);
        chk("rst_x6", x6, 0);
        rst = 1'b0;

        run_op("m00_s3_t1", 4, 2'b00, 3, 1, 1'b1, 2, 17, 1'b0);
        run_op("m00_s3_t2", 4, 2'b00, 3, 2, 1'b0, 0, lat_nosol, 1'b0);
        run_op("m10_s7_t2", 4, 2'b10, 7, 2, 1'b1, 0, 7, 1'b0);
        run_op("m11_s9_t1", 4, 2'b11, 9, 1, 1'b1, 1, 12, 1'b0);
        run_op("m01_s5_t0", 4, 2'b01, 5, 0, 1'b0, 0, lat_m01, 1'b0);
        run_op("m00_s0_t14", 4, 2'b00, 0, 14, 1'b1, 15, 82, 1'b0);
        run_op("busy_start", 4, 2'b00, 3, 1, 1'b1, 2, 17, 1'b1);

        // Reset in cycle 8 of a long search must abort without a done pulse
        @(negedge clk);
        set_in(4, 1'b1, 2'b00, 0, 14);
        done_seen = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            set_in(4, 1'b0, 2'b00, 0, 14);
            if (done4) done_seen++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", ready4, 1);
        chk("abort_found", found4, 0);
        chk("abort_x", x4, 0);
        for (int c = 0; c < 90; c++) begin
            @(negedge clk);
            if (done4) done_seen++;
        end
        chk("abort_no_done", done_seen, 0);
        run_op("after_abort", 4, 2'b11, 9, 1, 1'b1, 1, 12, 1'b0);

        run_op("w6_s0_t62", 6, 2'b00, 0, 62, 1'b1, 63, 2 + 64 * 7, 1'b0);
        for (int i = 0; i < 24; i++) run_rand($sformatf("rand4_%0d", i), 4);
        for (int i = 0; i < 12; i++) run_rand($sformatf("rand6_%0d", i), 6);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
